// File: rtl/mc8051_agu_arb_pkg.sv
// Shared address-mode codes and helpers for the mc8051 address generation
// and arbitration unit. Every pipeline stage uses this one code set.
package mc8051_agu_arb_pkg;

  // Width of the architectural mode code. Channel select fields may be wider.
  // Any nonzero bits above this width make the code undefined.
  localparam int AGU_CODE_W = 4;

  // Width of the channel index carried on the memory port.
  localparam int AGU_CH_W = 3;

  typedef enum logic [AGU_CODE_W-1:0] {
    AGU_ADDR_RS0    = 4'h0,  // {psw[4:3], instr[2:0]}
    AGU_ADDR_RS1    = 4'h1,  // {psw[4:3], 2'b00, instr[0]}
    AGU_ADDR_PC     = 4'h2,  // {pch, pcl}
    AGU_ADDR_PCPA   = 4'h3,  // {pch, pcl} + acc
    AGU_ADDR_DPTR   = 4'h4,  // {dph, dpl}
    AGU_ADDR_DPTRPA = 4'h5,  // {dph, dpl} + acc
    AGU_ADDR_INDX8  = 4'h6,  // s2 data buffer
    AGU_ADDR_SINDX8 = 4'h7,  // s3 data buffer
    AGU_ADDR_INDX16 = 4'h8,  // {s3b, s2b}
    AGU_ADDR_BITM0  = 4'h9,  // 0x20 + s2b[7:3]  (bit-addressable RAM byte)
    AGU_ADDR_BITM1  = 4'hA,  // {s2b[7:3], 3'b000} (SFR bit base)
    AGU_ADDR_SP     = 4'hB,  // stack pointer
    AGU_ADDR_SX     = 4'hC   // auxiliary stage buffer sx_0
  } agu_mode_e;

  // Round-robin pointer advance: winner + 1, wrapping at n channels.
  function automatic logic [AGU_CH_W-1:0] agu_ptr_next(
    input logic [AGU_CH_W-1:0] winner,
    input int                  n
  );
    if (int'(winner) >= n - 1) begin
      return '0;
    end
    return winner + 1'b1;
  endfunction

endpackage

// File: rtl/mc8051_agu_calc.sv
// Combinational mode-code to address calculator for one requesting channel.
// Arithmetic modes wrap modulo 2^ADDR_W; undefined codes yield address 0
// and raise sel_err.
module mc8051_agu_calc
  import mc8051_agu_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [7:0]        pch,
  input  logic [7:0]        pcl,
  input  logic [7:0]        acc,
  input  logic [7:0]        psw,
  input  logic [7:0]        sp,
  input  logic [7:0]        dpl,
  input  logic [7:0]        dph,
  input  logic [7:0]        instr,
  input  logic [7:0]        s2b,
  input  logic [7:0]        s3b,
  input  logic [7:0]        sx,
  output logic [ADDR_W-1:0] addr,
  output logic              sel_err
);

  logic [AGU_CODE_W-1:0] code;
  logic                  hi_nz;

  assign code = sel[AGU_CODE_W-1:0];

  // Select fields wider than the code are only legal with zero upper bits.
  if (SEL_W > AGU_CODE_W) begin : g_hi
    assign hi_nz = |sel[SEL_W-1:AGU_CODE_W];
  end else begin : g_nohi
    assign hi_nz = 1'b0;
  end

  // Only the register-bank bits of psw and the low instruction bits matter.
  logic unused_bits;
  assign unused_bits = ^{psw[7:5], psw[2:0], instr[7:3]};

  // Decode the mode code into an address; all sums are taken at ADDR_W.
  always_comb begin
    addr    = '0;
    sel_err = 1'b0;
    if (hi_nz) begin
      sel_err = 1'b1;
    end else begin
      case (code)
        AGU_ADDR_RS0:    addr = ADDR_W'({psw[4:3], instr[2:0]});
        AGU_ADDR_RS1:    addr = ADDR_W'({psw[4:3], 2'b00, instr[0]});
        AGU_ADDR_PC:     addr = ADDR_W'({pch, pcl});
        AGU_ADDR_PCPA:   addr = ADDR_W'({pch, pcl}) + ADDR_W'(acc);
        AGU_ADDR_DPTR:   addr = ADDR_W'({dph, dpl});
        AGU_ADDR_DPTRPA: addr = ADDR_W'({dph, dpl}) + ADDR_W'(acc);
        AGU_ADDR_INDX8:  addr = ADDR_W'(s2b);
        AGU_ADDR_SINDX8: addr = ADDR_W'(s3b);
        AGU_ADDR_INDX16: addr = ADDR_W'({s3b, s2b});
        AGU_ADDR_BITM0:  addr = ADDR_W'(8'h20) + ADDR_W'(s2b[7:3]);
        AGU_ADDR_BITM1:  addr = ADDR_W'({s2b[7:3], 3'b000});
        AGU_ADDR_SP:     addr = ADDR_W'(sp);
        AGU_ADDR_SX:     addr = ADDR_W'(sx);
        default:         sel_err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc8051_agu_arb.sv
// Address generation and arbitration unit for the mc8051 core.
// Each channel snapshots its computed address into a one-entry slot; the
// slots are then arbitrated (fixed or round-robin) onto a single registered
// memory request port with a valid/ready handshake.
module mc8051_agu_arb
  import mc8051_agu_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int N_CH   = 3,
  parameter int SEL_W  = 4,
  parameter int ARB_RR = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_CH-1:0]       i_ch_req,
  input  logic [N_CH*SEL_W-1:0] i_ch_sel,
  output logic [N_CH-1:0]       o_ch_ack,
  input  logic [7:0]            i_pch,
  input  logic [7:0]            i_pcl,
  input  logic [7:0]            i_acc,
  input  logic [7:0]            i_psw,
  input  logic [7:0]            i_sp,
  input  logic [7:0]            i_dpl,
  input  logic [7:0]            i_dph,
  input  logic [7:0]            i_s1_instr_buffer,
  input  logic [7:0]            i_s2_data_buffer,
  input  logic [7:0]            i_s3_data_buffer,
  input  logic [7:0]            i_sx_0,
  output logic                  o_mem_req,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [AGU_CH_W-1:0]   o_mem_ch,
  input  logic                  i_mem_ready,
  output logic                  o_sel_err,
  output logic                  o_busy
);

  logic [ADDR_W-1:0]   calc_addr [N_CH];
  logic [N_CH-1:0]     calc_err;
  logic [N_CH-1:0]     slot_vld;
  logic [ADDR_W-1:0]   slot_addr [N_CH];
  logic [AGU_CH_W-1:0] rr_ptr;

  logic                advance;
  logic                done;
  logic [N_CH-1:0]     own_oh;
  logic [N_CH-1:0]     done_oh;
  logic [N_CH-1:0]     capture;
  logic [N_CH-1:0]     cand;
  logic [N_CH-1:0]     ge_ptr;
  logic [N_CH-1:0]     pool;
  logic                win_found;
  logic [AGU_CH_W-1:0] win_idx;
  logic [ADDR_W-1:0]   win_addr;

  // One address calculator per channel, all fed from the same sources.
  for (genvar g = 0; g < N_CH; g++) begin : g_calc
    mc8051_agu_calc #(
      .ADDR_W (ADDR_W),
      .SEL_W  (SEL_W)
    ) u_calc (
      .sel     (i_ch_sel[g*SEL_W +: SEL_W]),
      .pch     (i_pch),
      .pcl     (i_pcl),
      .acc     (i_acc),
      .psw     (i_psw),
      .sp      (i_sp),
      .dpl     (i_dpl),
      .dph     (i_dph),
      .instr   (i_s1_instr_buffer),
      .s2b     (i_s2_data_buffer),
      .s3b     (i_s3_data_buffer),
      .sx      (i_sx_0),
      .addr    (calc_addr[g]),
      .sel_err (calc_err[g])
    );
  end

  // The port may take a new grant when idle or when the current one completes.
  assign advance = !o_mem_req || i_mem_ready;
  assign done    = o_mem_req && i_mem_ready;

  // Decode the owning channel; a slot in flight is never re-granted.
  always_comb begin
    own_oh = '0;
    for (int j = 0; j < N_CH; j++) begin
      own_oh[j] = o_mem_req && (int'(o_mem_ch) == j);
    end
  end

  assign done_oh = done ? own_oh : '0;
  assign capture = i_ch_req & ~slot_vld;
  assign cand    = slot_vld & ~own_oh;

  // Pick the winner: lowest candidate at or above the RR pointer, else the
  // lowest candidate overall (fixed mode treats every index as eligible).
  always_comb begin
    for (int j = 0; j < N_CH; j++) begin
      ge_ptr[j] = (ARB_RR == 0) || (j >= int'(rr_ptr));
    end
    pool      = (|(cand & ge_ptr)) ? (cand & ge_ptr) : cand;
    win_found = |pool;
    win_idx   = '0;
    win_addr  = slot_addr[0];
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (pool[j]) begin
        win_idx  = AGU_CH_W'(j);
        win_addr = slot_addr[j];
      end
    end
  end

  // Slot occupancy: clear on completion, set on capture of a new request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_vld <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (done_oh[k]) begin
          slot_vld[k] <= 1'b0;
        end else if (capture[k]) begin
          slot_vld[k] <= 1'b1;
        end
      end
    end
  end

  // Slot addresses are snapshots; later source changes do not reach them.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (capture[k]) begin
        slot_addr[k] <= calc_addr[k];
      end
    end
  end

  // Memory port, acknowledge and error pulses, round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_ch   <= '0;
      o_ch_ack   <= '0;
      o_sel_err  <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      o_ch_ack  <= done_oh;
      o_sel_err <= |(capture & calc_err);
      if (advance) begin
        o_mem_req <= win_found;
        if (win_found) begin
          o_mem_addr <= win_addr;
          o_mem_ch   <= win_idx;
          if (ARB_RR != 0) begin
            rr_ptr <= agu_ptr_next(win_idx, N_CH);
          end
        end
      end
    end
  end

  assign o_busy = (|slot_vld) || o_mem_req;

endmodule

// File: tb/tb_mc8051_agu_arb.sv
// Directed bench for mc8051_agu_arb: one fixed-priority and one round-robin
// instance share the architectural sources and mode codes but have their own
// request and ready inputs.
module tb_mc8051_agu_arb;
  import mc8051_agu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_f, req_r;
  logic [11:0] sel;
  logic        rdy_f, rdy_r;
  logic [7:0]  pch, pcl, acc, psw, sp, dpl, dph, instr, s2b, s3b, sx;

  logic [2:0]  ack_f, ack_r, ch_f, ch_r;
  logic [15:0] addr_f, addr_r;
  logic        mreq_f, mreq_r, err_f, err_r, busy_f, busy_r;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc8051_agu_arb #(.ADDR_W(16), .N_CH(3), .SEL_W(4), .ARB_RR(0)) u_fix (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_req(req_f), .i_ch_sel(sel),
    .o_ch_ack(ack_f), .i_pch(pch), .i_pcl(pcl), .i_acc(acc), .i_psw(psw),
    .i_sp(sp), .i_dpl(dpl), .i_dph(dph), .i_s1_instr_buffer(instr),
    .i_s2_data_buffer(s2b), .i_s3_data_buffer(s3b), .i_sx_0(sx),
    .o_mem_req(mreq_f), .o_mem_addr(addr_f), .o_mem_ch(ch_f),
    .i_mem_ready(rdy_f), .o_sel_err(err_f), .o_busy(busy_f)
  );

  mc8051_agu_arb #(.ADDR_W(16), .N_CH(3), .SEL_W(4), .ARB_RR(1)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_req(req_r), .i_ch_sel(sel),
    .o_ch_ack(ack_r), .i_pch(pch), .i_pcl(pcl), .i_acc(acc), .i_psw(psw),
    .i_sp(sp), .i_dpl(dpl), .i_dph(dph), .i_s1_instr_buffer(instr),
    .i_s2_data_buffer(s2b), .i_s3_data_buffer(s3b), .i_sx_0(sx),
    .o_mem_req(mreq_r), .o_mem_addr(addr_r), .o_mem_ch(ch_r),
    .i_mem_ready(rdy_r), .o_sel_err(err_r), .o_busy(busy_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int ch, input logic [3:0] code);
    sel[ch*4 +: 4] = code;
  endtask

  // One request on the fixed instance with ready held high.
  task automatic single(input string tag, input int ch, input logic [3:0] code,
                        input logic [15:0] exp_addr);
    set_sel(ch, code);
    req_f[ch] = 1'b1;
    rdy_f     = 1'b1;
    tick();
    tick();
    chk({tag, "_req"}, 32'(mreq_f), 32'd1);
    chk({tag, "_addr"}, 32'(addr_f), 32'(exp_addr));
    chk({tag, "_ch"}, 32'(ch_f), 32'(ch));
    tick();
    chk({tag, "_ack"}, 32'(ack_f), 32'(3'b001 << ch));
    req_f[ch] = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req_f = '0; req_r = '0; sel = '0; rdy_f = 1'b0; rdy_r = 1'b0;
    pch = '0; pcl = '0; acc = '0; psw = '0; sp = '0; dpl = '0; dph = '0;
    instr = '0; s2b = '0; s3b = '0; sx = '0;
    tick();
    tick();
    chk("rst_req", 32'(mreq_f), 32'd0);
    chk("rst_addr", 32'(addr_f), 32'd0);
    chk("rst_ch", 32'(ch_f), 32'd0);
    chk("rst_ack", 32'(ack_f), 32'd0);
    chk("rst_busy", 32'(busy_f), 32'd0);
    chk("rst_err", 32'(err_f), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single PC request: grant visible two edges after the request.
    pch = 8'h12; pcl = 8'h34;
    set_sel(0, AGU_ADDR_PC);
    req_f = 3'b001; rdy_f = 1'b1;
    tick();
    chk("pc_req_e1", 32'(mreq_f), 32'd0);
    chk("pc_busy_e1", 32'(busy_f), 32'd1);
    tick();
    chk("pc_req_e2", 32'(mreq_f), 32'd1);
    chk("pc_addr", 32'(addr_f), 32'h1234);
    chk("pc_ch", 32'(ch_f), 32'd0);
    tick();
    chk("pc_ack", 32'(ack_f), 32'b001);
    chk("pc_req_e3", 32'(mreq_f), 32'd0);
    req_f = 3'b000;
    tick();
    chk("pc_ack_off", 32'(ack_f), 32'b000);
    chk("pc_idle", 32'(busy_f), 32'd0);

    // Snapshot: psw changes after capture must not alter the address.
    psw = 8'h18; instr = 8'h27;
    set_sel(1, AGU_ADDR_RS1);
    req_f = 3'b010;
    tick();
    psw = 8'h00;
    tick();
    chk("snap_addr", 32'(addr_f), 32'h0019);
    chk("snap_ch", 32'(ch_f), 32'd1);
    tick();
    chk("snap_ack", 32'(ack_f), 32'b010);
    req_f = 3'b000;
    tick();

    // Address modes, including wrap-around.
    dph = 8'hFF; dpl = 8'hFF; acc = 8'h02;
    single("dptrpa", 0, AGU_ADDR_DPTRPA, 16'h0001);
    s2b = 8'hF8;
    single("bitm0", 2, AGU_ADDR_BITM0, 16'h003F);
    s3b = 8'hAB; s2b = 8'hCD;
    single("indx16", 1, AGU_ADDR_INDX16, 16'hABCD);
    psw = 8'h10; instr = 8'h05;
    single("rs0", 0, AGU_ADDR_RS0, 16'h0015);
    pch = 8'h12; pcl = 8'hFF; acc = 8'h02;
    single("pcpa", 2, AGU_ADDR_PCPA, 16'h1301);

    // Three simultaneous requests, three stalled cycles, then drain.
    pch = 8'h12; pcl = 8'h34; set_sel(0, AGU_ADDR_PC);
    dph = 8'h56; dpl = 8'h78; set_sel(1, AGU_ADDR_DPTR);
    sp  = 8'h07;              set_sel(2, AGU_ADDR_SP);
    rdy_f = 1'b0; rdy_r = 1'b0;
    req_f = 3'b111; req_r = 3'b111;
    tick();
    tick();
    chk("pri_s1_req", 32'(mreq_f), 32'd1);
    chk("pri_s1_addr", 32'(addr_f), 32'h1234);
    chk("rr_s1_ch", 32'(ch_r), 32'd0);
    tick();
    chk("pri_s2_addr", 32'(addr_f), 32'h1234);
    chk("pri_s2_ch", 32'(ch_f), 32'd0);
    tick();
    chk("pri_s3_addr", 32'(addr_f), 32'h1234);
    chk("pri_s3_ch", 32'(ch_f), 32'd0);
    chk("rr_s3_ch", 32'(ch_r), 32'd0);
    rdy_f = 1'b1; rdy_r = 1'b1;
    tick();
    chk("pri_g1_ch", 32'(ch_f), 32'd1);
    chk("pri_g1_addr", 32'(addr_f), 32'h5678);
    chk("pri_g1_req", 32'(mreq_f), 32'd1);
    chk("pri_ack0", 32'(ack_f), 32'b001);
    chk("rr_g1_ch", 32'(ch_r), 32'd1);
    chk("rr_ack0", 32'(ack_r), 32'b001);
    req_f[0] = 1'b0;
    tick();
    chk("pri_g2_ch", 32'(ch_f), 32'd2);
    chk("pri_g2_addr", 32'(addr_f), 32'h0007);
    chk("pri_ack1", 32'(ack_f), 32'b010);
    chk("rr_g2_ch", 32'(ch_r), 32'd2);
    chk("rr_ack1", 32'(ack_r), 32'b010);
    req_f[1] = 1'b0; req_r[1] = 1'b0;
    tick();
    chk("pri_end_req", 32'(mreq_f), 32'd0);
    chk("pri_ack2", 32'(ack_f), 32'b100);
    chk("rr_g3_ch", 32'(ch_r), 32'd0);
    chk("rr_g3_addr", 32'(addr_r), 32'h1234);
    chk("rr_g3_req", 32'(mreq_r), 32'd1);
    chk("rr_ack2", 32'(ack_r), 32'b100);
    req_f[2] = 1'b0; req_r[2] = 1'b0;
    tick();
    chk("pri_drained", 32'(busy_f), 32'd0);
    chk("rr_ack0b", 32'(ack_r), 32'b001);
    chk("rr_end_req", 32'(mreq_r), 32'd0);
    req_r[0] = 1'b0;
    tick();
    chk("rr_drained", 32'(busy_r), 32'd0);

    // Undefined code: address 0 and a one-cycle error pulse.
    set_sel(2, 4'hF);
    req_f = 3'b100; rdy_f = 1'b1;
    tick();
    chk("err_pulse", 32'(err_f), 32'd1);
    tick();
    chk("err_clear", 32'(err_f), 32'd0);
    chk("err_addr", 32'(addr_f), 32'h0000);
    chk("err_ch", 32'(ch_f), 32'd2);
    tick();
    chk("err_ack", 32'(ack_f), 32'b100);
    req_f = 3'b000;
    tick();

    // Reset during a stalled transfer aborts it without an acknowledge.
    set_sel(0, AGU_ADDR_PC);
    req_f = 3'b001; rdy_f = 1'b0;
    tick();
    tick();
    chk("ab_req_pre", 32'(mreq_f), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ab_req", 32'(mreq_f), 32'd0);
    chk("ab_addr", 32'(addr_f), 32'd0);
    chk("ab_ch", 32'(ch_f), 32'd0);
    chk("ab_busy", 32'(busy_f), 32'd0);
    rdy_f = 1'b1; req_f = 3'b000;
    tick();
    chk("ab_ack_rst", 32'(ack_f), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ab_ack_post", 32'(ack_f), 32'd0);
    tick();
    chk("ab_idle", 32'(mreq_f), 32'd0);
    chk("ab_ack_late", 32'(ack_f), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
